// File: rtl/regfile_access_pkg.sv
// Shared definitions for the register file access sequencer.
package regfile_access_pkg;

  localparam int unsigned ADDR_W_DFLT = 5;
  localparam int unsigned DATA_W_DFLT = 32;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_FILL,
    S_COPY
  } state_e;

endpackage

// File: rtl/regfile_fill_counter.sv
// Wrapping address counter and data incrementer used to sequence a range fill.
module regfile_fill_counter
  import regfile_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DFLT,
  parameter int unsigned DATA_W   = DATA_W_DFLT,
  parameter int unsigned FILL_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] start_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load a new range or advance one step; both address and data wrap naturally.
  always_comb begin
    addr_d = addr_q;
    end_d  = end_q;
    data_d = data_q;
    if (load) begin
      addr_d = start_addr;
      end_d  = end_addr;
      data_d = start_data;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      data_d = data_q + DATA_W'(FILL_INC);
    end
  end

  // Counter state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      end_q  <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      end_q  <= end_d;
      data_q <= data_d;
    end
  end

  assign addr = addr_q;
  assign data = data_q;
  assign last = (addr_q == end_q);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Command sequencer driving a dual-read/single-write register file.
module regfile_access_ctrl
  import regfile_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DFLT,
  parameter int unsigned DATA_W   = DATA_W_DFLT,
  parameter int unsigned FILL_INC = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_r_addr_a,
  output logic [ADDR_W-1:0] rf_r_addr_b,
  input  logic [DATA_W-1:0] rf_r_data_a,
  input  logic [DATA_W-1:0] rf_r_data_b,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_write_reg
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] r_addr_a_q, r_addr_a_d;
  logic [ADDR_W-1:0] r_addr_b_q, r_addr_b_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

  logic              cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic [DATA_W-1:0] cnt_data;

  regfile_fill_counter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .FILL_INC(FILL_INC)
  ) u_fill_counter (
    .clk       (clk),
    .rst_n     (Reset),
    .load      (cnt_load),
    .step      (cnt_step),
    .start_addr(cmd_addr_a),
    .end_addr  (cmd_addr_b),
    .start_data(cmd_data),
    .addr      (cnt_addr),
    .data      (cnt_data),
    .last      (cnt_last)
  );

  // Next-state logic: accept in IDLE, sequence each command, capture read results.
  always_comb begin
    state_d    = state_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    data_d     = data_q;
    r_addr_a_d = r_addr_a_q;
    r_addr_b_d = r_addr_b_q;
    rsp_a_d    = rsp_a_q;
    rsp_b_d    = rsp_b_q;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          data_d   = cmd_data;
          unique case (cmd_op)
            OP_WRITE: state_d = S_WRITE;
            OP_READ: begin
              // Read addresses are registered at accept so they hold afterwards.
              r_addr_a_d = cmd_addr_a;
              r_addr_b_d = cmd_addr_b;
              state_d    = S_READ;
            end
            OP_FILL: begin
              cnt_load = 1'b1;
              state_d  = S_FILL;
            end
            OP_COPY: begin
              r_addr_a_d = cmd_addr_a;
              state_d    = S_COPY;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        rsp_a_d = rf_r_data_a;
        rsp_b_d = rf_r_data_b;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      S_FILL: begin
        cnt_step = 1'b1;
        if (cnt_last) state_d = S_IDLE;
      end
      S_COPY:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      data_q     <= '0;
      r_addr_a_q <= '0;
      r_addr_b_q <= '0;
      rsp_a_q    <= '0;
      rsp_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      data_q     <= data_d;
      r_addr_a_q <= r_addr_a_d;
      r_addr_b_q <= r_addr_b_d;
      rsp_a_q    <= rsp_a_d;
      rsp_b_q    <= rsp_b_d;
    end
  end

  // Output decode; handshake and write enable are gated by reset so a reset edge never writes.
  always_comb begin
    cmd_ready    = Reset && (state_q == S_IDLE);
    rf_write_reg = 1'b0;
    rf_w_addr    = '0;
    rf_w_data    = '0;
    case (state_q)
      S_WRITE: begin
        rf_write_reg = Reset;
        rf_w_addr    = addr_a_q;
        rf_w_data    = data_q;
      end
      S_FILL: begin
        rf_write_reg = Reset;
        rf_w_addr    = cnt_addr;
        rf_w_data    = cnt_data;
      end
      S_COPY: begin
        rf_write_reg = Reset;
        rf_w_addr    = addr_b_q;
        rf_w_data    = rf_r_data_a;
      end
      default: ;
    endcase
  end

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data_a  = rsp_a_q;
  assign rsp_data_b  = rsp_b_q;
  assign busy        = (state_q != S_IDLE);
  assign rf_r_addr_a = r_addr_a_q;
  assign rf_r_addr_b = r_addr_b_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: bench-side register file, command-level model, directed tests.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr_a, cmd_addr_b;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic        busy;
  logic [4:0]  rf_r_addr_a, rf_r_addr_b, rf_w_addr;
  logic [31:0] rf_r_data_a, rf_r_data_b, rf_w_data;
  logic        rf_write_reg;
  logic        rf_load;

  regfile_access_ctrl dut (
    .clk         (clk),
    .Reset       (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr_a  (cmd_addr_a),
    .cmd_addr_b  (cmd_addr_b),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data_a  (rsp_data_a),
    .rsp_data_b  (rsp_data_b),
    .busy        (busy),
    .rf_r_addr_a (rf_r_addr_a),
    .rf_r_addr_b (rf_r_addr_b),
    .rf_r_data_a (rf_r_data_a),
    .rf_r_data_b (rf_r_data_b),
    .rf_w_addr   (rf_w_addr),
    .rf_w_data   (rf_w_data),
    .rf_write_reg(rf_write_reg)
  );

  always #5 clk = ~clk;

  // Bench register file: combinational reads, write on clock edge, fresh-load on rf_load.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
      rf_mem[0] <= 32'h0000FFFF;
      rf_mem[1] <= 32'hFFFF0000;
    end else if (rf_write_reg) begin
      rf_mem[rf_w_addr] <= rf_w_data;
    end
  end
  assign rf_r_data_a = rf_mem[rf_r_addr_a];
  assign rf_r_data_b = rf_mem[rf_r_addr_b];

  // Command-level model: expected register contents, write stream and response stream.
  logic [31:0] exp_mem [32];
  logic [4:0]  wq_a [$];
  logic [31:0] wq_d [$];
  logic [31:0] rq_a [$];
  logic [31:0] rq_b [$];
  logic [31:0] last_rsp_a, last_rsp_b;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_fresh();
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h0000FFFF;
    exp_mem[1] = 32'hFFFF0000;
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
    wq_a.push_back(a);
    wq_d.push_back(d);
    exp_mem[a] = d;
  endfunction

  // Fill writes ((b-a) mod 32)+1 registers, optionally truncated to max_w.
  function automatic void model_fill(input logic [4:0] a, input logic [4:0] b,
                                     input logic [31:0] d, input int max_w);
    int n;
    logic [4:0] span;
    span = b - a;
    n = int'(span) + 1;
    if (n > max_w) n = max_w;
    for (int k = 0; k < n; k++) model_write(a + 5'(k), d + 32'(k));
  endfunction

  function automatic void model_read(input logic [4:0] a, input logic [4:0] b);
    rq_a.push_back(exp_mem[a]);
    rq_b.push_back(exp_mem[b]);
  endfunction

  // Per-cycle compare of the write port and the response channel against the model.
  task automatic compare_outputs();
    logic [4:0]  ta;
    logic [31:0] td;
    if (rf_write_reg) begin
      chk("write_expected", {31'b0, wq_a.size() != 0}, 32'h1);
      if (wq_a.size() != 0) begin
        chk("rf_w_addr", {27'b0, rf_w_addr}, {27'b0, wq_a[0]});
        chk("rf_w_data", rf_w_data, wq_d[0]);
        ta = wq_a.pop_front();
        td = wq_d.pop_front();
      end
    end
    if (rsp_valid) begin
      chk("rsp_expected", {31'b0, rq_a.size() != 0}, 32'h1);
      if (rq_a.size() != 0) begin
        chk("rsp_data_a", rsp_data_a, rq_a[0]);
        chk("rsp_data_b", rsp_data_b, rq_b[0]);
        if (rsp_ready) begin
          td = rq_a.pop_front();
          td = rq_b.pop_front();
          last_rsp_a = rsp_data_a;
          last_rsp_b = rsp_data_b;
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] d);
    int t;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_data   = d;
    t = 0;
    while (!cmd_ready && t < 20) begin
      cyc();
      t++;
    end
    chk("cmd_ready_for_accept", {31'b0, cmd_ready}, 32'h1);
    cyc();
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom_range(0, 3));
    cmd_addr_a = 5'($urandom);
    cmd_addr_b = 5'($urandom);
    cmd_data   = $urandom;
  endtask

  task automatic wait_idle(input int rsp_delay, output int busy_cyc, output int wr_cyc,
                           output int first_rsp);
    int resp_cnt;
    busy_cyc  = 0;
    wr_cyc    = 0;
    resp_cnt  = 0;
    first_rsp = -1;
    while (busy && busy_cyc < 100) begin
      busy_cyc++;
      if (rf_write_reg) wr_cyc++;
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = busy_cyc;
        chk("cmd_ready_low_in_resp", {31'b0, cmd_ready}, 32'h0);
        rsp_ready = (resp_cnt >= rsp_delay);
        resp_cnt++;
      end
      cyc();
    end
    rsp_ready = 1'b0;
    chk("idle_after_cmd", {31'b0, busy}, 32'h0);
    chk("cmd_ready_after_cmd", {31'b0, cmd_ready}, 32'h1);
    chk("writes_pending", 32'(wq_a.size()), 32'h0);
    chk("rsps_pending", 32'(rq_a.size()), 32'h0);
  endtask

  task automatic rf_fresh();
    rf_load = 1'b1;
    cyc();
    rf_load = 1'b0;
    model_fresh();
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, rf_mem[i], exp_mem[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc, wc, fr;
    reset_n    = 1'b0;
    rf_load    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_data   = '0;
    rsp_ready  = 1'b0;
    model_fresh();
    repeat (3) cyc();

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_cmd_ready_forced", {31'b0, cmd_ready}, 32'h0);
    chk("rst_write_reg", {31'b0, rf_write_reg}, 32'h0);
    chk("rst_rsp_data_a", rsp_data_a, 32'h0);
    chk("rst_rsp_data_b", rsp_data_b, 32'h0);
    chk("rst_rf_addrs", {17'b0, rf_r_addr_a, rf_r_addr_b, rf_w_addr}, 32'h0);
    chk("rst_rf_w_data", rf_w_data, 32'h0);
    reset_n = 1'b1;
    rf_load = 1'b0;
    #1;
    chk("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'h1);

    // Fresh READ a=0 b=1
    model_read(5'd0, 5'd1);
    send(2'b01, 5'd0, 5'd1, 32'h0);
    wait_idle(0, bc, wc, fr);
    chk("read_first_rsp_cycle", 32'(fr), 32'd2);
    chk("read_busy_cycles", 32'(bc), 32'd2);
    chk("read0_literal", last_rsp_a, 32'h0000FFFF);
    chk("read1_literal", last_rsp_b, 32'hFFFF0000);

    // WRITE 5 then READ 5,5
    model_write(5'd5, 32'hDEADBEEF);
    send(2'b00, 5'd5, 5'd0, 32'hDEADBEEF);
    wait_idle(0, bc, wc, fr);
    chk("write_busy_cycles", 32'(bc), 32'd1);
    chk("write_wr_cycles", 32'(wc), 32'd1);
    model_read(5'd5, 5'd5);
    send(2'b01, 5'd5, 5'd5, 32'h0);
    wait_idle(0, bc, wc, fr);
    chk("read5a_literal", last_rsp_a, 32'hDEADBEEF);
    chk("read5b_literal", last_rsp_b, 32'hDEADBEEF);

    // FILL a=30 b=1 data=10 (wraps)
    rf_fresh();
    model_fill(5'd30, 5'd1, 32'd10, 32);
    send(2'b10, 5'd30, 5'd1, 32'd10);
    wait_idle(0, bc, wc, fr);
    chk("fill_busy_cycles", 32'(bc), 32'd4);
    chk("fill_wr_cycles", 32'(wc), 32'd4);
    chk("fill_r30", rf_mem[30], 32'd10);
    chk("fill_r31", rf_mem[31], 32'd11);
    chk("fill_r0", rf_mem[0], 32'd12);
    chk("fill_r1", rf_mem[1], 32'd13);
    chk("fill_r2", rf_mem[2], 32'd0);
    check_mem("fill_mem");

    // FILL a==b gives one write; data wrap at 2^32
    model_fill(5'd9, 5'd9, 32'h1234_5678, 32);
    send(2'b10, 5'd9, 5'd9, 32'h1234_5678);
    wait_idle(0, bc, wc, fr);
    chk("fill1_wr_cycles", 32'(wc), 32'd1);
    model_fill(5'd3, 5'd4, 32'hFFFF_FFFF, 32);
    send(2'b10, 5'd3, 5'd4, 32'hFFFF_FFFF);
    wait_idle(0, bc, wc, fr);
    chk("fillwrap_r4", rf_mem[4], 32'h0);
    check_mem("fill_small_mem");

    // COPY 1 -> 7 on fresh file, then READ 7,1
    rf_fresh();
    model_write(5'd7, exp_mem[1]);
    send(2'b11, 5'd1, 5'd7, 32'h0);
    wait_idle(0, bc, wc, fr);
    chk("copy_wr_cycles", 32'(wc), 32'd1);
    model_read(5'd7, 5'd1);
    send(2'b01, 5'd7, 5'd1, 32'h0);
    wait_idle(0, bc, wc, fr);
    chk("copy_dst_literal", last_rsp_a, 32'hFFFF0000);
    chk("copy_src_literal", last_rsp_b, 32'hFFFF0000);

    // COPY src==dst rewrites the same value
    model_write(5'd0, exp_mem[0]);
    send(2'b11, 5'd0, 5'd0, 32'h0);
    wait_idle(0, bc, wc, fr);
    check_mem("copy_mem");

    // READ with rsp_ready held low for 5 RESP cycles
    model_read(5'd0, 5'd7);
    send(2'b01, 5'd0, 5'd7, 32'h0);
    wait_idle(5, bc, wc, fr);
    chk("stall_busy_cycles", 32'(bc), 32'd7);

    // FILL 0..31 interrupted by reset during the 4th fill cycle
    rf_fresh();
    model_fill(5'd0, 5'd31, 32'd100, 3);
    send(2'b10, 5'd0, 5'd31, 32'd100);
    repeat (3) cyc();
    chk("fill_busy_before_rst", {31'b0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_gates_write", {31'b0, rf_write_reg}, 32'h0);
    chk("rst_gates_ready", {31'b0, cmd_ready}, 32'h0);
    cyc();
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    cyc();
    chk("abort_r2", rf_mem[2], 32'd102);
    chk("abort_r3", rf_mem[3], 32'd0);
    chk("abort_writes_pending", 32'(wq_a.size()), 32'h0);
    check_mem("abort_mem");

    // READ after the abort sees the partially filled registers
    model_read(5'd0, 5'd3);
    send(2'b01, 5'd0, 5'd3, 32'h0);
    wait_idle(1, bc, wc, fr);
    chk("post_abort_r0", last_rsp_a, 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Command sequencer that acts as the initiator for the team's 32x32-bit dual-read/single-write register file. It accepts host commands over a valid/ready interface and drives the register file read and write ports. The four commands are single write, dual read, range fill and register copy. Dual-read results return over a valid/ready response channel. It sits between the test/host logic and the register file, and is the only agent driving the register file write port.

Parameters:
ADDR_W, 5, register address width (32 registers; all address arithmetic wraps modulo 2^ADDR_W)
DATA_W, 32, register data width
FILL_INC, 1, value added to the fill data after each FILL step (wraps modulo 2^DATA_W)

Ports:
clk  in  1  clock, all logic on rising edge
Reset  in  1  reset, synchronous, active-low (Reset=0 resets at the next clk edge)
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 COPY
cmd_addr_a  in  ADDR_W  WRITE addr / READ port-A addr / FILL start / COPY source
cmd_addr_b  in  ADDR_W  READ port-B addr / FILL end (inclusive) / COPY destination
cmd_data  in  DATA_W  WRITE data / FILL initial data
rsp_valid  out  1  READ result valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_data_a  out  DATA_W  port-A read result
rsp_data_b  out  DATA_W  port-B read result
busy  out  1  high in any non-IDLE state
rf_r_addr_a  out  ADDR_W  to register file read address A
rf_r_addr_b  out  ADDR_W  to register file read address B
rf_r_data_a  in  DATA_W  from register file (combinational read)
rf_r_data_b  in  DATA_W  from register file (combinational read)
rf_w_addr  out  ADDR_W  to register file write address
rf_w_data  out  DATA_W  to register file write data
rf_write_reg  out  1  to register file write enable

Behaviour:
- Reset state:
  - State IDLE; rsp_valid=0; rsp_data_a/b=0; busy=0.
  - All rf_* address and data outputs = 0.
  - cmd_ready=1 after reset is released.
  - While Reset=0: cmd_ready and rf_write_reg are forced to 0 combinationally, so no register file write happens on a reset edge.
  - This block does not drive the register file's own reset.
- cmd_ready = (state==IDLE). On accept, latch op, addresses and data into internal registers; the next state is chosen by op.
- WRITE (1 cycle):
  - rf_write_reg=1, rf_w_addr=addr_a, rf_w_data=data.
  - Write commits on the edge leaving WRITE; back to IDLE.
  - A command accepted at edge E0 writes at E1; cmd_ready is high again after E1.
- READ:
  - In READ state, rf_r_addr_a=addr_a and rf_r_addr_b=addr_b.
  - rf_r_data_a/b are captured into rsp_data_a/b on the edge leaving READ; go to RESP.
  - RESP: rsp_valid=1; data held stable until rsp_ready=1, then IDLE.
  - Latency: accept at E0, rsp_valid high after E1.
  - rsp_ready high in the first RESP cycle gives a 3-cycle command turnaround.
- FILL:
  - Address counter starts at addr_a and data register at data.
  - Each FILL cycle writes the current (addr, data), then addr+=1 (mod 32) and data+=FILL_INC (mod 2^DATA_W).
  - Terminates after the cycle that writes addr_b, then IDLE.
  - Write count = ((addr_b-addr_a) mod 32)+1.
  - addr_a==addr_b gives exactly 1 write; addr_a>addr_b wraps through 31 to 0; a=0,b=31 gives 32 writes.
- COPY (1 cycle):
  - rf_r_addr_a=src, rf_w_addr=dst, rf_w_data=rf_r_data_a, rf_write_reg=1.
  - src==dst performs a write of the unchanged value.
- Ordering: commands are strictly serialised, so a READ after a WRITE/FILL/COPY always observes the completed writes.
- cmd_op and the other cmd_* fields are ignored when cmd_ready=0.
- Reset=0 mid-operation: the FILL/READ/RESP in progress is abandoned with no further writes; rsp_valid drops to 0 at that edge.
- Outside WRITE/FILL/COPY, rf_write_reg=0 and rf_r_addr_* hold their last driven values.

Decomposition:
- Shared package regfile_access_pkg holds:
  - op code constants OP_WRITE, OP_READ, OP_FILL, OP_COPY;
  - state encoding S_IDLE, S_WRITE, S_READ, S_RESP, S_FILL, S_COPY;
  - ADDR_W and DATA_W defaults.
- One natural sub-module, regfile_fill_counter: wrapping address counter plus data incrementer with load/step/last outputs.

Test Plan:
- Register file freshly reset (reg0=0000FFFF, reg1=FFFF0000); READ a=0 b=1 -> rsp_valid after E1, rsp_data_a=32'h0000FFFF, rsp_data_b=32'hFFFF0000.
- WRITE addr=5 data=32'hDEADBEEF, then READ a=5 b=5 -> both outputs 32'hDEADBEEF; rf_write_reg high for exactly 1 cycle.
- FILL a=30 b=1 data=10 -> regs 30,31,0,1 = 10,11,12,13; busy high 4 cycles; reg2 still 0; reg0 overwritten (12).
- COPY src=1 dst=7 on fresh register file -> READ 7 returns 32'hFFFF0000; reg1 unchanged.
- READ with rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout; accepted the cycle rsp_ready=1, cmd_ready=1 next cycle.
- FILL a=0 b=31 data=100, Reset=0 during the 4th FILL cycle -> regs 0..2 = 100..102, reg3 unwritten, regs 4..31 unchanged, busy=0; cmd_ready=1 after Reset returns high.
